// File: rtl/apmu_ibex_pkg.sv
// Shared APMU Ibex types: RF write request payload, write-source encoding and starve counter width.
package apmu_ibex_pkg;

  localparam int unsigned RfArbStarveCntW = 8;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_wr_req_t;

  typedef enum logic [1:0] {
    RF_WR_SRC_ID,
    RF_WR_SRC_LSU,
    RF_WR_SRC_PMC,
    RF_WR_SRC_NONE
  } rf_wr_src_e;

endpackage

// File: rtl/apmu_ibex_rf_wr_fifo.sv
// In-order FIFO of RF write requests with per-entry read-address match outputs for hazard detection.
module apmu_ibex_rf_wr_fifo
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  rf_wr_req_t       push_data_i,
  input  logic             pop_i,
  output rf_wr_req_t       head_o,
  output logic             full_o,
  output logic             empty_o,
  input  logic [4:0]       rd_addr_a_i,
  input  logic [4:0]       rd_addr_b_i,
  output logic [Depth-1:0] match_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  rf_wr_req_t      mem_q [Depth];
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < Depth; i++) begin : g_match
    logic [PtrW-1:0] off;
    assign off        = PtrW'(i) - rd_ptr_q;
    assign match_o[i] = (CntW'(off) < cnt_q) && (mem_q[i].waddr != 5'd0) &&
                        ((mem_q[i].waddr == rd_addr_a_i) || (mem_q[i].waddr == rd_addr_b_i));
  end

endmodule

// File: rtl/apmu_ibex_rf_wr_arbiter.sv
// RF write-port arbiter: ID > LSU > buffered PMC writes; optional starvation guard
// enabled by APMU_RF_ARB_STARVE_GUARD_EN.
module apmu_ibex_rf_wr_arbiter
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned PmcFifoDepth = 2,
  parameter int unsigned StarveLimit  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_we_i,
  input  logic [4:0]  id_waddr_i,
  input  logic [31:0] id_wdata_i,
  input  logic        lsu_we_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        pmc_valid_i,
  input  logic [4:0]  pmc_waddr_i,
  input  logic [31:0] pmc_wdata_i,
  output logic        pmc_ready_o,
  input  logic [4:0]  rd_addr_a_i,
  input  logic [4:0]  rd_addr_b_i,
  output logic        pmc_raw_hazard_o,
  output logic        id_stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        pmc_pending_o,
  output logic        conflict_err_o
);

  if (PmcFifoDepth < 2 || (PmcFifoDepth & (PmcFifoDepth - 1)) != 0) begin : g_bad_depth
    $error("PmcFifoDepth must be a power of two >= 2");
  end
  if (StarveLimit < 1 || StarveLimit >= (1 << RfArbStarveCntW)) begin : g_bad_limit
    $error("StarveLimit must be in 1..255");
  end

  rf_wr_req_t              fifo_head;
  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [PmcFifoDepth-1:0] fifo_match;
  rf_wr_src_e              src;
  logic                    conflict_q;

  assign pmc_ready_o      = !fifo_full;
  assign fifo_push        = pmc_valid_i && !fifo_full && (pmc_waddr_i != 5'd0);
  assign fifo_pop         = (src == RF_WR_SRC_PMC);
  assign pmc_pending_o    = !fifo_empty;
  assign pmc_raw_hazard_o = |fifo_match;
  assign conflict_err_o   = conflict_q;

  apmu_ibex_rf_wr_fifo #(
    .Depth(PmcFifoDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (fifo_push),
    .push_data_i('{waddr: pmc_waddr_i, wdata: pmc_wdata_i}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .rd_addr_a_i(rd_addr_a_i),
    .rd_addr_b_i(rd_addr_b_i),
    .match_o    (fifo_match)
  );

  // Fixed-priority grant and write-port mux.
  always_comb begin
    src        = RF_WR_SRC_NONE;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (id_we_i) begin
      src        = RF_WR_SRC_ID;
      rf_waddr_o = id_waddr_i;
      rf_wdata_o = id_wdata_i;
    end else if (lsu_we_i) begin
      src        = RF_WR_SRC_LSU;
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
    end else if (!fifo_empty) begin
      src        = RF_WR_SRC_PMC;
      rf_waddr_o = fifo_head.waddr;
      rf_wdata_o = fifo_head.wdata;
    end
  end

  assign rf_we_o = rst_ni && (src != RF_WR_SRC_NONE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conflict_q <= 1'b0;
    end else if (id_we_i && lsu_we_i) begin
      conflict_q <= 1'b1;
    end
  end

`ifdef APMU_RF_ARB_STARVE_GUARD_EN
  localparam logic [RfArbStarveCntW-1:0] Limit = RfArbStarveCntW'(StarveLimit);

  logic [RfArbStarveCntW-1:0] starve_cnt_q, starve_cnt_d;
  logic                       id_stall_q;

  // Count cycles the queued head is passed over; saturate at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != Limit) begin
      starve_cnt_d = starve_cnt_q + RfArbStarveCntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
      id_stall_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      id_stall_q   <= (starve_cnt_d == Limit);
    end
  end

  assign id_stall_o = id_stall_q;
`else
  assign id_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_apmu_ibex_rf_wr_arbiter.sv
// Bench for apmu_ibex_rf_wr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_apmu_ibex_rf_wr_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;
`ifdef APMU_RF_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        id_we_i, lsu_we_i, pmc_valid_i;
  logic [4:0]  id_waddr_i, lsu_waddr_i, pmc_waddr_i, rd_addr_a_i, rd_addr_b_i;
  logic [31:0] id_wdata_i, lsu_wdata_i, pmc_wdata_i;
  logic        pmc_ready_o, pmc_raw_hazard_o, id_stall_o, rf_we_o, pmc_pending_o, conflict_err_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  apmu_ibex_rf_wr_arbiter #(
    .PmcFifoDepth(DEPTH),
    .StarveLimit (LIMIT)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .id_we_i         (id_we_i),
    .id_waddr_i      (id_waddr_i),
    .id_wdata_i      (id_wdata_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_waddr_i     (lsu_waddr_i),
    .lsu_wdata_i     (lsu_wdata_i),
    .pmc_valid_i     (pmc_valid_i),
    .pmc_waddr_i     (pmc_waddr_i),
    .pmc_wdata_i     (pmc_wdata_i),
    .pmc_ready_o     (pmc_ready_o),
    .rd_addr_a_i     (rd_addr_a_i),
    .rd_addr_b_i     (rd_addr_b_i),
    .pmc_raw_hazard_o(pmc_raw_hazard_o),
    .id_stall_o      (id_stall_o),
    .rf_we_o         (rf_we_o),
    .rf_waddr_o      (rf_waddr_o),
    .rf_wdata_o      (rf_wdata_o),
    .pmc_pending_o   (pmc_pending_o),
    .conflict_err_o  (conflict_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_cnf, m_stall;
  int   m_blk;
  int   n_total = 0;
  int   n_bad = 0;

  bit          e_ready, e_pend, e_haz, e_stall, e_cnf, e_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  // Model state advance from the inputs present just before a clock edge.
  task automatic model_edge();
    int sz;
    bit popped;
    if (!rst_ni) begin
      q.delete();
      m_cnf = 1'b0;
      m_blk = 0;
      m_stall = 1'b0;
      return;
    end
    sz = q.size();
    popped = !id_we_i && !lsu_we_i && sz > 0;
    m_cnf = m_cnf | (id_we_i && lsu_we_i);
    if (popped) void'(q.pop_front());
    if (pmc_valid_i && sz < DEPTH && pmc_waddr_i != 5'd0) q.push_back('{pmc_waddr_i, pmc_wdata_i});
    if (sz == 0 || popped) m_blk = 0;
    else if (m_blk < LIMIT) m_blk++;
    m_stall = GUARD && (m_blk == LIMIT);
  endtask

  task automatic model_out();
    e_ready = q.size() < DEPTH;
    e_pend  = q.size() != 0;
    e_haz   = 1'b0;
    foreach (q[i]) if (q[i].a == rd_addr_a_i || q[i].a == rd_addr_b_i) e_haz = 1'b1;
    e_stall = m_stall;
    e_cnf   = m_cnf;
    e_we = 1'b1; e_waddr = 5'd0; e_wdata = 32'd0;
    if (id_we_i) begin e_waddr = id_waddr_i; e_wdata = id_wdata_i; end
    else if (lsu_we_i) begin e_waddr = lsu_waddr_i; e_wdata = lsu_wdata_i; end
    else if (q.size() > 0) begin e_waddr = q[0].a; e_wdata = q[0].d; end
    else e_we = 1'b0;
    if (!rst_ni) e_we = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    id_we_i = 0; id_waddr_i = 0; id_wdata_i = 0;
    lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
    pmc_valid_i = 0; pmc_waddr_i = 0; pmc_wdata_i = 0;
    rd_addr_a_i = 0; rd_addr_b_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    tick(); tick();
    id_we_i = 1'b1; id_waddr_i = 5'd4;
    settle();
    n_total++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_we got=%0b exp=0", rf_we_o); end
    n_total++; if (pmc_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%0b exp=1", pmc_ready_o); end
    n_total++; if (pmc_pending_o !== 1'b0) begin n_bad++; $display("FAIL rst_pending got=%0b exp=0", pmc_pending_o); end
    n_total++; if (pmc_raw_hazard_o !== 1'b0) begin n_bad++; $display("FAIL rst_hazard got=%0b exp=0", pmc_raw_hazard_o); end
    n_total++; if (id_stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%0b exp=0", id_stall_o); end
    n_total++; if (conflict_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_conflict got=%0b exp=0", conflict_err_o); end
    idle();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_pmc_single();
    pmc_valid_i = 1'b1; pmc_waddr_i = 5'd5; pmc_wdata_i = 32'hDEAD_BEEF;
    settle();
    n_total++; if (pmc_ready_o !== 1'b1) begin n_bad++; $display("FAIL single_ready got=%0b exp=1", pmc_ready_o); end
    n_total++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL single_nowrite got=%0b exp=0", rf_we_o); end
    tick();
    idle();
    settle();
    n_total++; if (rf_we_o !== 1'b1) begin n_bad++; $display("FAIL single_we got=%0b exp=1", rf_we_o); end
    n_total++; if (rf_waddr_o !== 5'd5) begin n_bad++; $display("FAIL single_waddr got=%0d exp=5", rf_waddr_o); end
    n_total++; if (rf_wdata_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_wdata got=%h exp=deadbeef", rf_wdata_o); end
    tick();
    settle();
    n_total++; if (pmc_pending_o !== 1'b0) begin n_bad++; $display("FAIL single_pending got=%0b exp=0", pmc_pending_o); end
    n_total++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL single_after_we got=%0b exp=0", rf_we_o); end
  endtask

  task automatic test_id_block();
    id_we_i = 1'b1; id_waddr_i = 5'd3; id_wdata_i = 32'h3333_0000;
    pmc_valid_i = 1'b1; pmc_waddr_i = 5'd7; pmc_wdata_i = 32'hA1;
    tick();
    pmc_waddr_i = 5'd9; pmc_wdata_i = 32'hB2;
    tick();
    pmc_waddr_i = 5'd11; pmc_wdata_i = 32'hC3;
    rd_addr_a_i = 5'd9; rd_addr_b_i = 5'd1;
    settle();
    n_total++; if (pmc_ready_o !== 1'b0) begin n_bad++; $display("FAIL blk_ready got=%0b exp=0", pmc_ready_o); end
    n_total++; if (rf_waddr_o !== 5'd3) begin n_bad++; $display("FAIL blk_id_waddr got=%0d exp=3", rf_waddr_o); end
    n_total++; if (pmc_raw_hazard_o !== 1'b1) begin n_bad++; $display("FAIL blk_hazard_a got=%0b exp=1", pmc_raw_hazard_o); end
    rd_addr_a_i = 5'd4; rd_addr_b_i = 5'd7;
    #1;
    n_total++; if (pmc_raw_hazard_o !== 1'b1) begin n_bad++; $display("FAIL blk_hazard_b got=%0b exp=1", pmc_raw_hazard_o); end
    rd_addr_a_i = 5'd3; rd_addr_b_i = 5'd0;
    #1;
    n_total++; if (pmc_raw_hazard_o !== 1'b0) begin n_bad++; $display("FAIL blk_hazard_none got=%0b exp=0", pmc_raw_hazard_o); end
    tick(); tick();
    idle();
    settle();
    n_total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'hA1)
      begin n_bad++; $display("FAIL blk_drain0 got=%0b/%0d/%h exp=1/7/a1", rf_we_o, rf_waddr_o, rf_wdata_o); end
    tick();
    settle();
    n_total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd9 || rf_wdata_o !== 32'hB2)
      begin n_bad++; $display("FAIL blk_drain1 got=%0b/%0d/%h exp=1/9/b2", rf_we_o, rf_waddr_o, rf_wdata_o); end
    tick();
    settle();
    n_total++; if (pmc_pending_o !== 1'b0) begin n_bad++; $display("FAIL blk_empty got=%0b exp=0", pmc_pending_o); end
  endtask

  task automatic test_x0();
    pmc_valid_i = 1'b1; pmc_waddr_i = 5'd0; pmc_wdata_i = 32'h1234_5678;
    settle();
    n_total++; if (pmc_ready_o !== 1'b1) begin n_bad++; $display("FAIL x0_ready got=%0b exp=1", pmc_ready_o); end
    tick();
    idle();
    settle();
    n_total++; if (pmc_pending_o !== 1'b0) begin n_bad++; $display("FAIL x0_pending got=%0b exp=0", pmc_pending_o); end
    n_total++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL x0_we got=%0b exp=0", rf_we_o); end
  endtask

  task automatic test_conflict();
    id_we_i = 1'b1; id_waddr_i = 5'd1; id_wdata_i = 32'h0000_0111;
    lsu_we_i = 1'b1; lsu_waddr_i = 5'd2; lsu_wdata_i = 32'h0000_0222;
    settle();
    n_total++; if (rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h111)
      begin n_bad++; $display("FAIL cnf_winner got=%0d/%h exp=1/111", rf_waddr_o, rf_wdata_o); end
    n_total++; if (conflict_err_o !== 1'b0) begin n_bad++; $display("FAIL cnf_early got=%0b exp=0", conflict_err_o); end
    tick();
    idle();
    settle();
    n_total++; if (conflict_err_o !== 1'b1) begin n_bad++; $display("FAIL cnf_set got=%0b exp=1", conflict_err_o); end
    tick(); tick(); tick();
    settle();
    n_total++; if (conflict_err_o !== 1'b1) begin n_bad++; $display("FAIL cnf_sticky got=%0b exp=1", conflict_err_o); end
  endtask

  task automatic test_guard();
    id_we_i = 1'b1; id_waddr_i = 5'd3; id_wdata_i = 32'h3;
    pmc_valid_i = 1'b1; pmc_waddr_i = 5'd12; pmc_wdata_i = 32'hCAFE;
    tick();
    pmc_valid_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      settle();
      n_total++; if (id_stall_o !== (GUARD && k >= 9))
        begin n_bad++; $display("FAIL guard_stall_c%0d got=%0b exp=%0b", k, id_stall_o, GUARD && k >= 9); end
      tick();
    end
    id_we_i = 1'b0;
    settle();
    n_total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd12 || rf_wdata_o !== 32'hCAFE)
      begin n_bad++; $display("FAIL guard_land got=%0b/%0d/%h exp=1/12/cafe", rf_we_o, rf_waddr_o, rf_wdata_o); end
    n_total++; if (id_stall_o !== GUARD) begin n_bad++; $display("FAIL guard_hold got=%0b exp=%0b", id_stall_o, GUARD); end
    tick();
    settle();
    n_total++; if (id_stall_o !== 1'b0) begin n_bad++; $display("FAIL guard_fall got=%0b exp=0", id_stall_o); end
    n_total++; if (pmc_pending_o !== 1'b0) begin n_bad++; $display("FAIL guard_empty got=%0b exp=0", pmc_pending_o); end
  endtask

  task automatic test_reset_mid();
    id_we_i = 1'b1; id_waddr_i = 5'd3;
    pmc_valid_i = 1'b1; pmc_waddr_i = 5'd20; pmc_wdata_i = 32'h20;
    tick();
    pmc_waddr_i = 5'd21; pmc_wdata_i = 32'h21;
    tick();
    idle();
    rst_ni = 1'b0;
    rd_addr_a_i = 5'd20; rd_addr_b_i = 5'd21;
    settle();
    n_total++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL rmid_forced_we got=%0b exp=0", rf_we_o); end
    tick();
    settle();
    n_total++; if (pmc_pending_o !== 1'b0) begin n_bad++; $display("FAIL rmid_pending got=%0b exp=0", pmc_pending_o); end
    n_total++; if (pmc_ready_o !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got=%0b exp=1", pmc_ready_o); end
    n_total++; if (pmc_raw_hazard_o !== 1'b0) begin n_bad++; $display("FAIL rmid_hazard got=%0b exp=0", pmc_raw_hazard_o); end
    n_total++; if (conflict_err_o !== 1'b0) begin n_bad++; $display("FAIL rmid_conflict got=%0b exp=0", conflict_err_o); end
    n_total++; if (id_stall_o !== 1'b0) begin n_bad++; $display("FAIL rmid_stall got=%0b exp=0", id_stall_o); end
    rst_ni = 1'b1;
    settle();
    n_total++; if (rf_we_o !== 1'b0) begin n_bad++; $display("FAIL rmid_release_we got=%0b exp=0", rf_we_o); end
    tick();
    settle();
    n_total++; if (rf_we_o !== 1'b0 || pmc_pending_o !== 1'b0)
      begin n_bad++; $display("FAIL rmid_after got=%0b/%0b exp=0/0", rf_we_o, pmc_pending_o); end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_ni      = ($urandom_range(0, 63) != 0);
      id_we_i     = ($urandom_range(0, 3) == 0);
      id_waddr_i  = 5'($urandom);
      id_wdata_i  = $urandom;
      lsu_we_i    = ($urandom_range(0, 3) == 0);
      lsu_waddr_i = 5'($urandom);
      lsu_wdata_i = $urandom;
      pmc_valid_i = ($urandom_range(0, 1) == 0);
      pmc_waddr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      pmc_wdata_i = $urandom;
      rd_addr_a_i = 5'($urandom);
      rd_addr_b_i = ($urandom_range(0, 1) == 0 && q.size() > 0) ? q[0].a : 5'($urandom);
      settle();
      model_out();
      n_total++; if (rf_we_o !== e_we) begin n_bad++; $display("FAIL rnd_we c%0d got=%0b exp=%0b", c, rf_we_o, e_we); end
      if (e_we) begin
        n_total++; if (rf_waddr_o !== e_waddr || rf_wdata_o !== e_wdata)
          begin n_bad++; $display("FAIL rnd_wr c%0d got=%0d/%h exp=%0d/%h", c, rf_waddr_o, rf_wdata_o, e_waddr, e_wdata); end
      end
      n_total++; if (pmc_ready_o !== e_ready) begin n_bad++; $display("FAIL rnd_ready c%0d got=%0b exp=%0b", c, pmc_ready_o, e_ready); end
      n_total++; if (pmc_pending_o !== e_pend) begin n_bad++; $display("FAIL rnd_pending c%0d got=%0b exp=%0b", c, pmc_pending_o, e_pend); end
      n_total++; if (pmc_raw_hazard_o !== e_haz) begin n_bad++; $display("FAIL rnd_hazard c%0d got=%0b exp=%0b", c, pmc_raw_hazard_o, e_haz); end
      n_total++; if (id_stall_o !== e_stall) begin n_bad++; $display("FAIL rnd_stall c%0d got=%0b exp=%0b", c, id_stall_o, e_stall); end
      n_total++; if (conflict_err_o !== e_cnf) begin n_bad++; $display("FAIL rnd_conflict c%0d got=%0b exp=%0b", c, conflict_err_o, e_cnf); end
      tick();
    end
    idle();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    @(posedge clk_i);
    #1;
    test_reset();
    test_pmc_single();
    test_id_block();
    test_x0();
    test_conflict();
    test_guard();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
